program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 103 ++++++++++
 tb/tb_program_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: PC, instruction register and 8-deep return stack.
// Fetch, skip, goto/call/return and computed-jump control.
module program_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_rd_en,
  input  logic        instr_flush,
  input  logic        pc_incr_en,
  input  logic        pc_j_en,
  input  logic        pc_j_and_push_en,
  input  logic        pc_j_by_pop_en,
  input  logic        pcl_wr_en,
  input  logic [7:0]  pcl_wr_data,
  input  logic [4:0]  pclath,
  input  logic [13:0] prog_data,
  output logic [12:0] prog_addr,
  output logic [13:0] instr_current,
  output logic [12:0] pc,
  output logic [2:0]  stack_ptr,
  output logic        stack_ovf,
  output logic        stack_unf
);

  logic [12:0] pc_q, pc_d;
  logic [13:0] ir_q, ir_d;
  logic [2:0]  sp_q, sp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [12:0] mem_q [8];
  logic        push;
  logic        pop;
  logic [2:0]  sp_dec;
  logic [12:0] j_tgt;
  logic [12:0] c_tgt;

  assign sp_dec = sp_q - 3'd1;
  assign j_tgt  = {pclath[4:3], ir_q[10:0]};
  assign c_tgt  = {pclath, pcl_wr_data};

  // Next PC, IR and stack bookkeeping from the prioritised controls.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    pop   = pc_j_by_pop_en;
    push  = pc_j_and_push_en && !pc_j_by_pop_en;
    if (pop) begin
      pc_d = mem_q[sp_dec];
      sp_d = sp_dec;
      if (cnt_q == 4'd0) unf_d = 1'b1;
      else               cnt_d = cnt_q - 4'd1;
    end else if (push) begin
      pc_d = j_tgt;
      sp_d = sp_q + 3'd1;
      if (cnt_q == 4'd8) ovf_d = 1'b1;
      else               cnt_d = cnt_q + 4'd1;
    end else if (pc_j_en) begin
      pc_d = j_tgt;
    end else if (pcl_wr_en) begin
      pc_d = c_tgt;
    end else if (pc_incr_en) begin
      pc_d = pc_q + 13'd1;
    end
    if (instr_flush)      ir_d = 14'h0000;
    else if (instr_rd_en) ir_d = prog_data;
  end

  // Architectural state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= 13'h0000;
      ir_q  <= 14'h0000;
      sp_q  <= 3'd0;
      cnt_q <= 4'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-address storage; push writes the already-advanced PC.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[sp_q] <= pc_q;
  end

  assign prog_addr     = pc_q;
  assign pc            = pc_q;
  assign instr_current = ir_q;
  assign stack_ptr     = sp_q;
  assign stack_ovf     = ovf_q;
  assign stack_unf     = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: reference model plus
// directed scenarios with literal expectations.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_rd_en, instr_flush, pc_incr_en;
  logic        pc_j_en, pc_j_and_push_en, pc_j_by_pop_en;
  logic        pcl_wr_en;
  logic [7:0]  pcl_wr_data;
  logic [4:0]  pclath;
  logic [13:0] prog_data;
  logic [12:0] prog_addr, pc;
  logic [13:0] instr_current;
  logic [2:0]  stack_ptr;
  logic        stack_ovf, stack_unf;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_j_and_push_en(pc_j_and_push_en),
    .pc_j_by_pop_en(pc_j_by_pop_en),
    .pcl_wr_en(pcl_wr_en), .pcl_wr_data(pcl_wr_data),
    .pclath(pclath), .prog_data(prog_data),
    .prog_addr(prog_addr), .instr_current(instr_current),
    .pc(pc), .stack_ptr(stack_ptr),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  function automatic logic [13:0] rom(input logic [12:0] a);
    case (a)
      13'h0000: rom = 14'h3055;
      13'h0004: rom = 14'h2923;
      13'h000F: rom = 14'h2040;
      default:  rom = {1'b0, a} ^ 14'h2A5A;
    endcase
  endfunction

  assign prog_data = rom(prog_addr);

  // Reference model: live return addresses kept as a LIFO queue,
  // plus the raw slot contents for stale reads on underflow.
  int          m_pc, m_ir, m_ptr;
  bit          m_ovf, m_unf;
  logic [12:0] m_stk [$];
  logic [12:0] m_ring [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",        32'(pc),            32'(m_pc));
      chk("prog_addr", 32'(prog_addr),     32'(m_pc));
      chk("ir",        32'(instr_current), 32'(m_ir));
      chk("sp",        32'(stack_ptr),     32'(m_ptr));
      chk("ovf",       32'(stack_ovf),     32'(m_ovf));
      chk("unf",       32'(stack_unf),     32'(m_unf));
    end
  end

  // Drive one cycle, predict its effect, commit at the edge.
  task automatic step(input bit r, input bit fl, input bit rd,
                      input bit inc, input bit j, input bit jp,
                      input bit po, input bit pw,
                      input logic [7:0] d, input logic [4:0] lath);
    int n_pc, n_ir, n_ptr, w_idx;
    bit n_ovf, n_unf, w_en;
    logic [12:0] n_stk [$];
    logic [12:0] w_val;
    rst = r; instr_flush = fl; instr_rd_en = rd;
    pc_incr_en = inc; pc_j_en = j; pc_j_and_push_en = jp;
    pc_j_by_pop_en = po; pcl_wr_en = pw;
    pcl_wr_data = d; pclath = lath;
    n_pc = m_pc; n_ir = m_ir; n_ptr = m_ptr;
    n_ovf = m_ovf; n_unf = m_unf; n_stk = m_stk;
    w_en = 0; w_idx = 0; w_val = '0;
    if (r) begin
      n_pc = 0; n_ir = 0; n_ptr = 0;
      n_ovf = 0; n_unf = 0; n_stk.delete();
    end else begin
      if (po) begin
        n_ptr = (m_ptr + 7) % 8;
        if (n_stk.size() > 0) n_pc = n_stk.pop_back();
        else begin
          n_unf = 1;
          n_pc = m_ring[n_ptr];
        end
      end else if (jp) begin
        w_en = 1; w_idx = m_ptr; w_val = 13'(m_pc);
        n_ptr = (m_ptr + 1) % 8;
        n_stk.push_back(13'(m_pc));
        if (n_stk.size() > 8) begin
          n_ovf = 1;
          void'(n_stk.pop_front());
        end
        n_pc = lath[4:3] * 2048 + (m_ir % 2048);
      end else if (j) begin
        n_pc = lath[4:3] * 2048 + (m_ir % 2048);
      end else if (pw) begin
        n_pc = lath * 256 + d;
      end else if (inc) begin
        n_pc = (m_pc + 1) % 8192;
      end
      if (fl)      n_ir = 0;
      else if (rd) n_ir = rom(13'(m_pc));
    end
    @(posedge clk);
    m_pc = n_pc; m_ir = n_ir; m_ptr = n_ptr;
    m_ovf = n_ovf; m_unf = n_unf; m_stk = n_stk;
    if (w_en) m_ring[w_idx] = w_val;
    #1;
  endtask

  task automatic idle();  step(0,0,0,0,0,0,0,0,8'h0,5'h0); endtask
  task automatic fetch(); step(0,0,1,1,0,0,0,0,8'h0,5'h0); endtask
  task automatic reset(); step(1,1,1,1,1,1,1,1,8'hFF,5'h1F); endtask
  task automatic cjmp(input logic [4:0] l, input logic [7:0] d);
    step(0,0,0,0,0,0,0,1,d,l);
  endtask

  initial begin
    step(1,0,0,0,0,0,0,0,8'h0,5'h0);
    reset();
    chk_en = 1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_sp", 32'(stack_ptr), 32'h0);
    chk("rst_ir", 32'(instr_current), 32'h0);

    // first fetch after reset
    fetch();
    chk("f0_ir", 32'(instr_current), 32'h3055);
    chk("f0_pc", 32'(prog_addr), 32'h1);
    idle();
    chk("idle_pc", 32'(pc), 32'h1);

    // goto with flush, then fetch at target
    cjmp(5'h0, 8'h04);
    fetch();
    chk("goto_setup", 32'(pc), 32'h5);
    step(0,1,0,0,1,0,0,0,8'h0,5'b11000);
    chk("goto_pc", 32'(pc), 32'h1923);
    chk("goto_ir", 32'(instr_current), 32'h0);
    fetch();
    chk("goto_fetch", 32'(instr_current), 32'h3379);
    chk("goto_pc2", 32'(pc), 32'h1924);

    // call then return
    cjmp(5'h0, 8'h0F);
    fetch();
    step(0,1,0,0,0,1,0,0,8'h0,5'h0);
    chk("call_pc", 32'(pc), 32'h40);
    chk("call_sp", 32'(stack_ptr), 32'h1);
    fetch(); fetch();
    step(0,1,0,0,0,0,1,0,8'h0,5'h0);
    chk("ret_pc", 32'(pc), 32'h10);
    chk("ret_sp", 32'(stack_ptr), 32'h0);
    chk("ret_flags", 32'({stack_ovf, stack_unf}), 32'h0);

    // nine calls overflow, nine returns underflow
    reset();
    for (int k = 0; k < 9; k++) begin
      cjmp(5'h0, 8'(8'h20 + k));
      fetch();
      step(0,1,0,0,0,1,0,0,8'h0,5'h0);
    end
    chk("ovf_flag", 32'(stack_ovf), 32'h1);
    chk("ovf_sp", 32'(stack_ptr), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step(0,1,0,0,0,0,1,0,8'h0,5'h0);
      chk("pop_pc", 32'(pc), 32'(13'h29 - k));
    end
    chk("no_unf", 32'(stack_unf), 32'h0);
    step(0,1,0,0,0,0,1,0,8'h0,5'h0);
    chk("unf_flag", 32'(stack_unf), 32'h1);
    idle();
    chk("unf_sticky", 32'({stack_ovf, stack_unf}), 32'h3);

    // pop beats push and jump in the same cycle
    reset();
    cjmp(5'h0, 8'h33);
    step(0,0,0,0,0,1,0,0,8'h0,5'h0);
    step(0,0,0,1,1,1,1,1,8'h55,5'h0);
    chk("prio_pc", 32'(pc), 32'h33);
    chk("prio_sp", 32'(stack_ptr), 32'h0);

    // PC wrap and computed jump over increment
    cjmp(5'h1F, 8'hFF);
    step(0,0,0,1,0,0,0,0,8'h0,5'h0);
    chk("wrap_pc", 32'(pc), 32'h0);
    step(0,0,0,1,0,0,0,1,8'h80,5'h02);
    chk("pcl_pc", 32'(pc), 32'h280);

    // skip: flush with fetch and increment
    fetch();
    step(0,1,1,1,0,0,0,0,8'h0,5'h0);
    chk("skip_ir", 32'(instr_current), 32'h0);
    chk("skip_pc", 32'(pc), 32'h282);

    // reset during a call
    step(0,1,0,0,0,1,0,0,8'h0,5'h0);
    step(1,1,0,0,0,1,0,0,8'h0,5'h0);
    chk("rstcall_sp", 32'(stack_ptr), 32'h0);
    chk("rstcall_pc", 32'(pc), 32'h0);
    idle();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
